// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Encodes field-level instruction requests (R-type, LW, SW, BEQ, ADDI) into
//   32-bit MIPS words. It writes them one per cycle into consecutive
//   instruction-memory words starting at address 0. The core is held in reset
//   (cpu_hold) until a load session ends with an accepted in_last request.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   start               one-cycle pulse that begins or restarts a session
//   in_valid / in_ready request handshake (ready only while loading)
//   in_kind, in_alu     instruction kind and R-type ALU operation select
//   in_rs/in_rt/in_rd   register fields
//   in_imm              raw 16-bit immediate / branch offset
//   in_last             final request of the session
//   imem_we/addr/wdata  registered instruction-memory write port
//   cpu_hold            keeps the core in reset until a session completes
//   busy/done/err       LOAD / DONE / ERR state indicators
//   count               words written in the current session
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64   // must not exceed 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_LW    = 3'd1;
  localparam logic [2:0] K_SW    = 3'd2;
  localparam logic [2:0] K_BEQ   = 3'd3;
  localparam logic [2:0] K_ADDI  = 3'd4;

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  // The session count doubles as the write pointer. The block never wraps,
  // so count stays below DEPTH whenever it is used as an address.
  logic [ADDR_W:0]     r_count;

  logic [5:0]          w_funct;
  logic                w_alu_ok;
  logic [31:0]         w_word;
  logic                w_enc_ok;
  logic                w_accept;
  logic                w_at_end;

  // ALU select to R-type funct field.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_funct  = 6'b000000;
    w_alu_ok = 1'b1;
    case (in_alu)
      3'b010:  w_funct = 6'b100000;  // add
      3'b110:  w_funct = 6'b100010;  // sub
      3'b000:  w_funct = 6'b100100;  // and
      3'b001:  w_funct = 6'b100101;  // or
      3'b111:  w_funct = 6'b101010;  // slt
      default: w_alu_ok = 1'b0;
    endcase
  end

  // Field-level request to 32-bit instruction word (shamt is always zero).
  always_comb begin
    w_word   = 32'h0000_0000;
    w_enc_ok = 1'b1;
    case (in_kind)
      K_RTYPE: begin
        w_word   = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, w_funct};
        w_enc_ok = w_alu_ok;
      end
      K_LW:    w_word = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:    w_word = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ:   w_word = {6'b000100, in_rs, in_rt, in_imm};
      K_ADDI:  w_word = {6'b001000, in_rs, in_rt, in_imm};
      default: w_enc_ok = 1'b0;
    endcase
  end

  assign w_accept = in_valid && (r_state == S_LOAD);
  assign w_at_end = (r_count == LAST_PTR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_we <= 1'b0;  // the write strobe is a single-cycle pulse
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_count <= '0;
          end
        end
        S_LOAD: begin
          // start is ignored here, even alongside a handshake.
          if (w_accept) begin
            if (!w_enc_ok) begin
              r_state <= S_ERR;  // rejected request: nothing written
            end else begin
              r_we    <= 1'b1;
              r_addr  <= r_count[ADDR_W-1:0];
              r_wdata <= w_word;
              r_count <= r_count + (ADDR_W+1)'(1);
              if (in_last)       r_state <= S_DONE;
              else if (w_at_end) r_state <= S_ERR;  // memory full, no wrap
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            r_state <= S_LOAD;
            r_count <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign in_ready   = (r_state == S_LOAD);
  assign busy       = (r_state == S_LOAD);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign cpu_hold   = (r_state != S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Directed and randomized requests drive the loader. Each expected memory write
// is queued when a request is issued. A negedge monitor pops the queue and
// compares every write the DUT presents. Status outputs are compared against an
// abstract session model after each cycle of stimulus.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [2:0]        in_alu;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_alu     (in_alu),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned addr;
    longint unsigned data;
    int              at_cyc;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Session model: mode and number of words written.
  int m_mode = M_IDLE;
  int m_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_valid(input int kind, input int alu);
    if (kind > 4) return 1'b0;
    if (kind == 0) return (alu == 2 || alu == 6 || alu == 0 || alu == 1 || alu == 7);
    return 1'b1;
  endfunction

  // Instruction word built arithmetically from its field weights.
  function automatic longint unsigned ref_word(input int kind, input int alu, input int rs,
                                               input int rt, input int rd, input int imm);
    longint unsigned op;
    longint unsigned low;
    op = 0;
    low = longint'(imm);
    case (kind)
      0: begin
        case (alu)
          2:       low = 32;  // add
          6:       low = 34;  // sub
          0:       low = 36;  // and
          1:       low = 37;  // or
          7:       low = 42;  // slt
          default: low = 0;
        endcase
        low = low + longint'(rd) * 64'd2048;
      end
      1: op = 35;
      2: op = 43;
      3: op = 4;
      4: op = 8;
      default: op = 0;
    endcase
    return op * 64'd67108864 + longint'(rs) * 64'd2097152 + longint'(rt) * 64'd65536 + low;
  endfunction

  // Write monitor: every presented write must match the head of the queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'd0, imem_wdata}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), e.addr);
        check("wr_data", 64'(imem_wdata), e.data);
        check("wr_cycle", 64'(cyc), 64'(e.at_cyc));
      end
    end
  end

  task automatic check_status();
    check("in_ready", 64'(in_ready), 64'(m_mode == M_LOAD));
    check("busy",     64'(busy),     64'(m_mode == M_LOAD));
    check("done",     64'(done),     64'(m_mode == M_DONE));
    check("err",      64'(err),      64'(m_mode == M_ERR));
    check("cpu_hold", 64'(cpu_hold), 64'(m_mode != M_DONE));
    check("count",    64'(count),    64'(m_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_mode = M_IDLE;
    m_cnt  = 0;
    check("rst_we",    64'(imem_we),    64'd0);
    check("rst_addr",  64'(imem_addr),  64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check_status();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (m_mode != M_LOAD) begin
      m_mode = M_LOAD;
      m_cnt  = 0;
    end
    check_status();
  endtask

  // One cycle of request stimulus; called right after a posedge (+1).
  task automatic send(input int kind, input int alu, input int rs, input int rt,
                      input int rd, input int imm, input bit last, input bit st);
    wr_t e;
    in_kind  = 3'(kind);
    in_alu   = 3'(alu);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_imm   = 16'(imm);
    in_last  = last;
    in_valid = 1'b1;
    start    = st && (m_mode == M_LOAD);
    check("ready_pre", 64'(in_ready), 64'(m_mode == M_LOAD));
    if (m_mode == M_LOAD) begin
      if (ref_valid(kind, alu)) begin
        e.addr   = longint'(m_cnt);
        e.data   = ref_word(kind, alu, rs, rt, rd, imm);
        e.at_cyc = cyc + 1;
        exp_q.push_back(e);
        m_cnt++;
        if (last)                m_mode = M_DONE;
        else if (m_cnt == DEPTH) m_mode = M_ERR;
      end else begin
        m_mode = M_ERR;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    check_status();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = '0; in_alu = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    @(posedge clk);
    #1;
    do_reset();

    // A request in IDLE is ignored.
    send(1, 0, 1, 2, 0, 16'h1234, 1'b0, 1'b0);

    // RTYPE add, then an invalid kind aborts the session.
    pulse_start();
    send(0, 3'b010, 1, 2, 3, 16'hBEEF, 1'b0, 1'b0);   // 0x00221820
    send(6, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Restart from ERR; four back-to-back writes end with in_last at DEPTH-1.
    pulse_start();
    send(1, 0, 0, 2, 9, 4,       1'b0, 1'b0);   // 0x8C020004
    send(2, 0, 1, 2, 9, 8,       1'b0, 1'b1);   // 0xAC220008, start ignored
    send(3, 0, 1, 2, 9, 16'hFFFF, 1'b0, 1'b0);  // 0x1022FFFF
    send(4, 0, 0, 1, 9, 5,       1'b1, 1'b0);   // 0x20010005

    // Restart from DONE; a single word completes again.
    pulse_start();
    send(4, 0, 3, 4, 0, 16'h8000, 1'b1, 1'b0);

    // slt, then invalid kind.
    pulse_start();
    send(0, 3'b111, 1, 2, 4, 0, 1'b0, 1'b0);    // 0x0022202A
    send(6, 0, 1, 2, 4, 0, 1'b0, 1'b0);

    // Overflow: DEPTH accepts without in_last, then ready drops.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(1, 0, i, i + 1, 0, i * 4, 1'b0, 1'b0);
    send(2, 0, 7, 7, 0, 7, 1'b0, 1'b0);

    // RTYPE with an invalid ALU select.
    pulse_start();
    send(0, 3'b011, 1, 2, 3, 0, 1'b0, 1'b0);

    // Reset while a write is on the port.
    pulse_start();
    send(2, 0, 5, 6, 0, 16'h0040, 1'b0, 1'b0);
    check("we_before_reset", 64'(imem_we), 64'd1);
    do_reset();

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      int n;
      if (m_mode != M_LOAD || $urandom_range(0, 3) == 0) pulse_start();
      n = int'($urandom_range(1, 6));
      for (int r = 0; r < n; r++) begin
        int kind;
        int alu;
        int pick;
        if ($urandom_range(0, 9) < 8) kind = int'($urandom_range(0, 4));
        else                          kind = int'($urandom_range(5, 7));
        pick = int'($urandom_range(0, 5));
        case (pick)
          0: alu = 2;
          1: alu = 6;
          2: alu = 0;
          3: alu = 1;
          4: alu = 7;
          default: alu = int'($urandom_range(0, 7));
        endcase
        send(kind, alu, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
             $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk);
          #1;
          check_status();
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the pipeline's instruction decode path: takes field-level instruction requests and encodes them into 32-bit MIPS words (R-type, LW, SW, BEQ, ADDI).
- Writes the encoded words sequentially into instruction memory.
- Holds the core in reset (cpu_hold) until a load completes.
- Sits between the testbench or boot host and the instruction memory write port.

Parameters:
- ADDR_W, 6, instruction memory word-address width.
- DEPTH, 64, number of words loadable; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  request valid.
- in_ready  output  1  block accepts a request this cycle.
- in_kind  input  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI; 5-7 invalid.
- in_alu  input  3  RTYPE only: 010 add, 110 sub, 000 and, 001 or, 111 slt; others invalid.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate or branch offset, passed through raw.
- in_last  input  1  marks the final request of the session.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  write word address.
- imem_wdata  output  32  encoded instruction.
- cpu_hold  output  1  keep the core in reset.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- err  output  1  high in ERR.
- count  output  ADDR_W+1  words written this session.

Behaviour:
- Reset (async): state=IDLE; cpu_hold=1; every other output 0, including imem_addr, imem_wdata and count.
  - Reset mid-load aborts immediately: imem_we drops asynchronously and no further writes occur.
- States: IDLE, LOAD, DONE, ERR.
- IDLE: in_ready=0, cpu_hold=1. start -> LOAD, with the write pointer and count cleared.
- LOAD: busy=1, in_ready=1.
  - Accept occurs when in_valid & in_ready.
  - On an accepted valid encoding, the next cycle shows imem_we=1 for exactly one cycle, with imem_addr=pointer and imem_wdata=encoded word. All three outputs are registered; latency is 1 cycle.
  - The pointer and count increment with that write.
  - in_ready stays 1, so back-to-back accepts give one write per cycle.
- Exit conditions from LOAD:
  - Accepted in_last -> DONE, effective on the same edge as the final write.
  - Accept at pointer DEPTH-1 without in_last -> word is written, then ERR (overflow). The block never wraps.
  - Accepted invalid in_kind, or RTYPE with invalid in_alu -> ERR. No write occurs; count is unchanged.
- DONE: done=1, cpu_hold=0, in_ready=0.
- ERR: err=1, cpu_hold=1, in_ready=0.
- start handling:
  - Ignored in LOAD.
  - In DONE or ERR: restarts -> LOAD; done and err clear, cpu_hold=1, pointer and count =0.
  - A start coincident with a handshake in LOAD is ignored; the handshake proceeds.
- in_valid outside LOAD is ignored and produces no write.
- When imem_we=0, imem_wdata and imem_addr hold their last values.
- Encoding (shamt always 0):
  - RTYPE: {000000, rs, rt, rd, 00000, funct}. funct mapping: add 100000, sub 100010, and 100100, or 100101, slt 101010. in_imm ignored.
  - LW: {100011, rs, rt, imm}. SW: {101011, rs, rt, imm}. BEQ: {000100, rs, rt, imm}. ADDI: {001000, rs, rt, imm}. in_rd ignored for all four.

Test Plan:
- reset, start, then RTYPE add rs=1 rt=2 rd=3 with in_last=0 -> next cycle imem_we=1, addr=0, wdata=0x00221820; count=1.
- Back-to-back accepts: LW rs=0 rt=2 imm=4; SW rs=1 rt=2 imm=8; BEQ rs=1 rt=2 imm=0xFFFF; ADDI rs=0 rt=1 imm=5 (in_last=1).
  - Required writes on consecutive cycles: 0x8C020004 @0, 0xAC220008 @1, 0x1022FFFF @2, 0x20010005 @3.
  - Then done=1, cpu_hold=0, count=4.
- RTYPE slt rs=1 rt=2 rd=4 at addr 0, then in_kind=6 -> first write 0x0022202A; then err=1, no second write, count=1, cpu_hold=1.
- DEPTH=4: 4 accepts, all with in_last=0 -> writes to addrs 0-3, then err=1; the fifth in_valid sees in_ready=0.
- Assert reset in the cycle imem_we=1 during LOAD -> imem_we=0 immediately; state IDLE, cpu_hold=1, count=0.
- In DONE, pulse start, then load one word with in_last=1 -> done deasserts on restart; word written at addr 0; done=1 again with count=1.
